// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter that also presents the
// Gray code of the count, registered on the same edge as the binary value.
// Optional feature macro: GRAY_COUNTER_CHECK_EN
//   defined   -> shadow register plus a sticky o_err flag on any count step
//                whose registered Gray transition does not change exactly one bit
//   undefined -> no shadow logic, o_err tied to 0
module gray_counter #(
  parameter int BW_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_up,
  input  logic               i_load,
  input  logic [BW_DATA-1:0] i_load_data,
  output logic [BW_DATA-1:0] o_bin,
  output logic [BW_DATA-1:0] o_gray,
  output logic               o_wrap,
  output logic               o_err
);

  localparam logic [BW_DATA-1:0] ONE = BW_DATA'(1);

  logic [BW_DATA-1:0] bin_d;
  logic [BW_DATA-1:0] bin_q;
  logic [BW_DATA-1:0] gray_d;
  logic [BW_DATA-1:0] gray_q;
  logic               wrap_d;
  logic               wrap_q;
  logic               step_d;

  // Reflected binary code of a binary word
  function automatic logic [BW_DATA-1:0] bin2gray(input logic [BW_DATA-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next count: load beats enable; wrap flags only count steps across the boundary
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step_d = 1'b0;
    if (i_load) begin
      bin_d = i_load_data;
    end else if (i_en) begin
      step_d = 1'b1;
      if (i_up) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
    end
    // Gray is taken from next-bin so the output is a clean register, not a decode
    gray_d = bin2gray(bin_d);
  end

  // Count, Gray and wrap registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bin  = bin_q;
  assign o_gray = gray_q;
  assign o_wrap = wrap_q;

`ifdef GRAY_COUNTER_CHECK_EN
  logic [BW_DATA-1:0] shadow_d;
  logic [BW_DATA-1:0] shadow_q;
  logic               step_q;
  logic               err_d;
  logic               err_q;

  // Number of set bits in a word
  function automatic int unsigned popcount(input logic [BW_DATA-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < BW_DATA; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

  // Previous Gray word is compared against the current one only after a count step
  always_comb begin
    shadow_d = gray_q;
    err_d    = err_q;
    if (step_q && (popcount(gray_q ^ shadow_q) != 32'd1)) begin
      err_d = 1'b1;
    end
  end

  // Shadow, step marker and sticky error registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_q <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (BW_DATA = 8): vector table, directed
// corner sequences, and randomized traffic against an arithmetic reference model.
module tb_gray_counter;

  localparam int BW = 8;
  localparam int MOD = 1 << BW;

  logic          i_clk;
  logic          i_rst;
  logic          i_en;
  logic          i_up;
  logic          i_load;
  logic [BW-1:0] i_load_data;
  logic [BW-1:0] o_bin;
  logic [BW-1:0] o_gray;
  logic          o_wrap;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integer count modulo 2^BW
  int m_bin  = 0;
  int m_wrap = 0;

  gray_counter #(.BW_DATA(BW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_up        (i_up),
    .i_load      (i_load),
    .i_load_data (i_load_data),
    .o_bin       (o_bin),
    .o_gray      (o_gray),
    .o_wrap      (o_wrap),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit            ld;
    logic [BW-1:0] d;
    bit            en;
    bit            up;
    logic [BW-1:0] eb;
    logic [BW-1:0] eg;
    bit            ew;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int gray_of(input int n);
    return n ^ (n / 2);
  endfunction

  function automatic int ones(input int v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  // One clock: drive inputs, advance the model, land 1 time unit after the edge
  task automatic cyc(input bit ld, input logic [BW-1:0] d, input bit en, input bit up);
    i_load = ld; i_load_data = d; i_en = en; i_up = up;
    @(posedge i_clk);
    #1;
    if (ld) begin
      m_bin = int'(d); m_wrap = 0;
    end else if (en && up) begin
      m_wrap = (m_bin == MOD - 1) ? 1 : 0;
      m_bin  = (m_bin + 1) % MOD;
    end else if (en) begin
      m_wrap = (m_bin == 0) ? 1 : 0;
      m_bin  = (m_bin + MOD - 1) % MOD;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_bin"},  32'(o_bin),  32'(m_bin));
    chk({tag, "_gray"}, 32'(o_gray), 32'(gray_of(m_bin)));
    chk({tag, "_wrap"}, 32'(o_wrap), 32'(m_wrap));
    chk({tag, "_err"},  32'(o_err),  32'd0);
  endtask

  task automatic do_reset();
    i_load = 0; i_en = 0; i_up = 0; i_load_data = '0;
    i_rst = 1'b1;
    #3;
    i_rst = 1'b0;
    m_bin = 0; m_wrap = 0;
  endtask

  initial begin
    int prev_gray;
    i_rst = 1'b1; i_load = 0; i_en = 0; i_up = 0; i_load_data = '0;
    #12;
    chk("reset_bin",  32'(o_bin),  32'd0);
    chk("reset_gray", 32'(o_gray), 32'd0);
    chk("reset_wrap", 32'(o_wrap), 32'd0);
    chk("reset_err",  32'(o_err),  32'd0);
    @(posedge i_clk); #1;
    do_reset();

    // Vector table from the reset state
    vt[0]  = '{0, 8'h00, 1, 1, 8'h01, 8'h01, 0};
    vt[1]  = '{0, 8'h00, 1, 1, 8'h02, 8'h03, 0};
    vt[2]  = '{1, 8'h01, 0, 0, 8'h01, 8'h01, 0};
    vt[3]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 0};
    vt[4]  = '{0, 8'h00, 1, 0, 8'hFF, 8'h80, 1};
    vt[5]  = '{0, 8'h00, 0, 0, 8'hFF, 8'h80, 0};
    vt[6]  = '{1, 8'hFF, 1, 1, 8'hFF, 8'h80, 0};
    vt[7]  = '{0, 8'h00, 1, 1, 8'h00, 8'h00, 1};
    vt[8]  = '{0, 8'h00, 1, 0, 8'hFF, 8'h80, 1};
    vt[9]  = '{1, 8'h5A, 1, 0, 8'h5A, 8'h77, 0};
    vt[10] = '{0, 8'h00, 1, 1, 8'h5B, 8'h76, 0};
    vt[11] = '{0, 8'h00, 0, 1, 8'h5B, 8'h76, 0};
    vt[12] = '{1, 8'h00, 0, 0, 8'h00, 8'h00, 0};
    vt[13] = '{0, 8'h00, 1, 0, 8'hFF, 8'h80, 1};
    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].ld, vt[i].d, vt[i].en, vt[i].up);
      chk($sformatf("vec%0d_bin", i),  32'(o_bin),  32'(vt[i].eb));
      chk($sformatf("vec%0d_gray", i), 32'(o_gray), 32'(vt[i].eg));
      chk($sformatf("vec%0d_wrap", i), 32'(o_wrap), 32'(vt[i].ew));
    end

    // Async reset mid-count at 0x5A, then first step after release
    cyc(1, 8'h5A, 0, 0);
    chk("pre_rst_bin", 32'(o_bin), 32'h5A);
    i_load = 0; i_en = 1; i_up = 1;
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_bin",  32'(o_bin),  32'd0);
    chk("async_rst_gray", 32'(o_gray), 32'd0);
    chk("async_rst_wrap", 32'(o_wrap), 32'd0);
    #1;
    i_rst = 1'b0;
    m_bin = 0; m_wrap = 0;
    cyc(0, 8'h00, 1, 1);
    chk("post_rst_bin",  32'(o_bin),  32'h01);
    chk("post_rst_gray", 32'(o_gray), 32'h01);

    // Full up sweep from 0
    do_reset();
    prev_gray = 0;
    for (int i = 0; i < MOD; i++) begin
      cyc(0, 8'h00, 1, 1);
      chk_model($sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d_onebit", i), 32'(ones(int'(o_gray) ^ prev_gray)), 32'd1);
      prev_gray = int'(o_gray);
    end
    chk("sweep_end_bin", 32'(o_bin), 32'h00);
    chk("sweep_end_wrap", 32'(o_wrap), 32'd1);

    // Hold and direction change around 0x10
    do_reset();
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 1);
    chk("at10_bin", 32'(o_bin), 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 1);
      chk($sformatf("hold%0d_bin", i),  32'(o_bin),  32'h10);
      chk($sformatf("hold%0d_gray", i), 32'(o_gray), 32'h18);
      chk($sformatf("hold%0d_wrap", i), 32'(o_wrap), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h00, 1, (i % 2 == 0));
      chk($sformatf("alt%0d_bin", i),  32'(o_bin),  (i % 2 == 0) ? 32'h11 : 32'h10);
      chk($sformatf("alt%0d_gray", i), 32'(o_gray), (i % 2 == 0) ? 32'h19 : 32'h18);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit ld, en, up;
      logic [BW-1:0] d;
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) == 1;
      d  = BW'($urandom);
      if ($urandom_range(0, 19) == 0) d = (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
      cyc(ld, d, en, up);
      chk_model($sformatf("rnd%0d", i));
    end

    // Gray-step checker
    do_reset();
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 1);
    chk("chk_pre_err", 32'(o_err), 32'd0);
`ifdef GRAY_COUNTER_CHECK_EN
    dut.shadow_q = o_gray ^ 8'h03;
`endif
    cyc(0, 8'h00, 0, 0);
`ifdef GRAY_COUNTER_CHECK_EN
    chk("chk_err_set", 32'(o_err), 32'd1);
`else
    chk("chk_err_off", 32'(o_err), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 1);
`ifdef GRAY_COUNTER_CHECK_EN
      chk($sformatf("chk_sticky%0d", i), 32'(o_err), 32'd1);
`else
      chk($sformatf("chk_zero%0d", i), 32'(o_err), 32'd0);
`endif
    end
    i_rst = 1'b1;
    #1;
    chk("chk_err_cleared", 32'(o_err), 32'd0);
    i_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
